// File: rtl/text_buffer_ctrl.sv
// text_buffer_ctrl: shares the single-port text buffer between display reads
// and bulk fill/clear writes, with reads always taking priority.
module text_buffer_ctrl #(
    parameter int cols = 128,
    parameter int rows = 48,
    parameter int char_width = 8,
    parameter int addr_width = 13,
    parameter logic [char_width-1:0] clear_char = 8'h20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fill_start,
    input  logic                  clear_start,
    input  logic                  rd_req,
    input  logic [addr_width-1:0] rd_addr,
    output logic [char_width-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  gen_req,
    input  logic                  gen_valid,
    input  logic [char_width-1:0] gen_char,
    output logic [addr_width-1:0] mem_addr,
    output logic                  mem_we,
    output logic [char_width-1:0] mem_wdata,
    input  logic [char_width-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done
);
    localparam logic [addr_width-1:0] last_addr = addr_width'(cols * rows - 1);

    typedef enum logic [1:0] {IDLE, FILL, CLEAR} state_t;

    state_t                state, state_nx;
    logic [addr_width-1:0] wr_addr;
    logic [char_width-1:0] hold;
    logic                  hold_valid, rd_pipe, write_now, wr, last;

    always_comb begin
        write_now = state == FILL && hold_valid && !rd_req;
        wr        = write_now || (state == CLEAR && !rd_req);
        last      = wr && wr_addr == last_addr;
        // no capture on the final write, so nothing is left stranded in hold
        gen_req   = state == FILL && (!hold_valid || write_now) && !last;
        state_nx  = state == IDLE ? (clear_start ? CLEAR : fill_start ? FILL : IDLE)
                  : last ? IDLE : state;
    end

    assign busy    = state != IDLE;
    assign rd_data = rd_valid ? mem_rdata : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wr_addr    <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
            rd_pipe    <= 1'b0;
            rd_valid   <= 1'b0;
            done       <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state    <= state_nx;
            rd_pipe  <= rd_req;
            rd_valid <= rd_pipe;
            done     <= last;
            mem_we   <= wr;
            if (rd_req)
                mem_addr <= rd_addr;
            else if (wr)
                mem_addr <= wr_addr;
            if (wr) begin
                mem_wdata <= state == CLEAR ? clear_char : hold;
                wr_addr   <= last ? '0 : wr_addr + 1'b1;
            end
            if (gen_req && gen_valid) begin
                hold       <= gen_char;
                hold_valid <= 1'b1;
            end else if (write_now) begin
                hold_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_text_buffer_ctrl.sv
// tb_text_buffer_ctrl: randomized scoreboard bench for text_buffer_ctrl with a
// behavioural buffer model and an in-order expected-write/expected-read queue.
module tb_text_buffer_ctrl;
    localparam int N = 128 * 48;

    logic        clk = 0, reset = 1, fill_start = 0, clear_start = 0;
    logic        rd_req = 0, gen_valid = 0;
    logic [12:0] rd_addr = 0;
    logic [7:0]  gen_char = 0, mem_rdata = 0;
    logic [7:0]  rd_data, mem_wdata;
    logic        rd_valid, gen_req, mem_we, busy, done;
    logic [12:0] mem_addr;

    always #5 clk = ~clk;

    text_buffer_ctrl dut (
        .clk(clk), .reset(reset), .fill_start(fill_start), .clear_start(clear_start),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .gen_req(gen_req), .gen_valid(gen_valid), .gen_char(gen_char),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done)
    );

    typedef struct {
        logic [12:0] a;
        logic [7:0]  d;
    } wr_t;

    logic [7:0] ram [8192];
    logic [7:0] ref_mem [8192];
    wr_t        exp_q[$];
    int         rd_q[$];
    int         checks = 0, failures = 0, done_cnt = 0, exp_done = 0;
    int         total_writes = 0, op_base = 0, ra = 0;
    int         gen_ctr = 0, gen_seed = 0, gen_mode = 0, gcyc = 0;
    bit         took = 0;
    logic       rd_d1 = 0, rd_d2 = 0, last_we = 0;
    logic [12:0] rd_a1 = 0;
    wr_t        e;

    initial for (int i = 0; i < 8192; i++) begin
        ram[i] = 8'h00;
        ref_mem[i] = 8'h00;
    end

    // synchronous single-port buffer, one cycle read latency
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // character generator: advances its sequence only when a character is taken
    initial forever begin
        @(negedge clk);
        took = gen_req && gen_valid;
        @(posedge clk);
        #1;
        if (took) gen_ctr++;
        gen_char  = 8'(gen_ctr + gen_seed);
        gen_valid = gen_mode == 0 || (gcyc / 3) % 2 == 0;
        gcyc++;
    end

    // monitor: reads are checked against the reference before this cycle's write lands
    always @(negedge clk) begin
        if (rd_valid || rd_d2) chk("rd_valid_timing", rd_valid, rd_d2);
        if (rd_d2) begin
            ra = rd_q.size() > 0 ? rd_q.pop_front() : 0;
            if (rd_valid) chk("rd_data", rd_data, ref_mem[ra]);
        end
        if (rd_d1) begin
            chk("arb_we", mem_we, 0);
            chk("arb_addr", mem_addr, rd_a1);
        end
        if (mem_we) begin
            total_writes++;
            if (exp_q.size() == 0) chk("extra_write", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("wr_addr", mem_addr, e.a);
                chk("wr_data", mem_wdata, e.d);
                ref_mem[e.a] = e.d;
            end
        end
        if (done) begin
            done_cnt++;
            chk("done_after_last_we", last_we, 1);
            chk("done_all_written", exp_q.size(), 0);
        end
        last_we = mem_we;
        rd_d2 = rd_d1;
        rd_d1 = rd_req;
        rd_a1 = rd_addr;
        if (rd_req) rd_q.push_back(int'(rd_addr));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input bit is_fill);
        wr_t x;
        op_base = total_writes;
        for (int k = 0; k < N; k++) begin
            x.a = 13'(k);
            x.d = is_fill ? 8'(gen_ctr + gen_seed + k) : 8'h20;
            exp_q.push_back(x);
        end
        exp_done++;
    endtask

    task automatic wait_done(input int budget, input int rd_prob);
        int n = 0;
        while (done_cnt < exp_done && n < budget) begin
            rd_req  = $urandom_range(0, 7) < rd_prob;
            rd_addr = 13'($urandom_range(0, N - 1));
            cyc();
            n++;
        end
        rd_req = 0;
        chk("done_timeout", done_cnt >= exp_done, 1);
        cyc();
        chk("busy_after_done", busy, 0);
    endtask

    task automatic pulse(input bit f, input bit c);
        fill_start  = f;
        clear_start = c;
        cyc();
        fill_start  = 0;
        clear_start = 0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_writes(input int cnt, input int budget);
        int n = 0;
        while (total_writes - op_base < cnt && n < budget) begin
            cyc();
            n++;
        end
        chk("write_progress_timeout", total_writes - op_base >= cnt, 1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_mem_we"}, mem_we, 0);
        chk({nm, "_mem_addr"}, mem_addr, 0);
        chk({nm, "_mem_wdata"}, mem_wdata, 0);
        chk({nm, "_gen_req"}, gen_req, 0);
        chk({nm, "_rd_valid"}, rd_valid, 0);
    endtask

    initial begin
        #2 reset = 0;
        repeat (3) cyc();
        chk_zero("reset");
        reset = 1;
        repeat (2) cyc();
        // clear without reads
        push_op(0);
        pulse(0, 1);
        wait_done(8000, 0);
        // fill from an incrementing generator starting at 0
        push_op(1);
        pulse(1, 0);
        wait_done(8000, 0);
        // read burst mid-fill, then sparse random reads
        gen_seed = 77;
        cyc();
        push_op(1);
        pulse(1, 0);
        wait_writes(50, 1000);
        rd_addr = 13'd100;
        rd_req  = 1;
        repeat (5) cyc();
        rd_req = 0;
        wait_done(12000, 1);
        // simultaneous starts: clear wins; a later fill_start is ignored
        push_op(0);
        pulse(1, 1);
        repeat (10) cyc();
        fill_start = 1;
        cyc();
        fill_start = 0;
        wait_done(9000, 1);
        repeat (20) cyc();
        chk("ignored_start_done_count", done_cnt, exp_done);
        // stalling generator with random reads
        gen_mode = 1;
        gen_seed = int'($urandom_range(0, 255));
        cyc();
        push_op(1);
        pulse(1, 0);
        wait_done(30000, 1);
        gen_mode = 0;
        // reset mid-fill aborts without done
        push_op(1);
        pulse(1, 0);
        wait_writes(3000, 5000);
        reset = 0;
        #1;
        chk_zero("abort");
        exp_q.delete();
        exp_done--;
        repeat (3) cyc();
        reset = 1;
        repeat (5) cyc();
        chk("abort_no_done", done_cnt, exp_done);
        // full clear after abort starts at address 0
        push_op(0);
        pulse(0, 1);
        wait_done(8000, 0);
        repeat (5) cyc();
        chk("final_done_count", done_cnt, exp_done);
        chk("final_writes_pending", exp_q.size(), 0);
        chk("final_reads_pending", rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
